// File: rtl/text_console.sv
// text_console: ASCII byte stream to screen-memory cell writes.
// Keeps a hardware cursor over a ROWS x COLS grid, interprets CR/LF/BS/TAB/FF,
// and runs a full-screen FILL sweep on FF (and optionally after reset).
module text_console #(
    parameter int          ROWS           = 60,
    parameter int          COLS           = 80,
    parameter logic [7:0]  FILL           = 8'h20,
    parameter int          TAB_W          = 8,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] char_in,
    input  logic       char_valid,
    output logic       char_ready,
    output logic       busy,
    output logic       we,
    output logic [5:0] wr_row,
    output logic [6:0] wr_col,
    output logic [7:0] wr_glyph,
    output logic [5:0] cur_row,
    output logic [6:0] cur_col
);

    typedef enum logic {IDLE, CLEAR} state_t;

    localparam logic [5:0] LAST_ROW = 6'(ROWS - 1);
    localparam logic [6:0] LAST_COL = 7'(COLS - 1);
    localparam logic [7:0] TAB_MASK = ~8'(TAB_W - 1);
    localparam logic [7:0] TAB_STEP = 8'(TAB_W);
    localparam logic [7:0] COLS_8   = 8'(COLS);
    localparam state_t     RST_ST   = CLEAR_ON_RESET ? CLEAR : IDLE;

    state_t     state, state_n;
    logic       we_n;
    logic [5:0] wr_row_n, cur_row_n, clr_row, clr_row_n;
    logic [6:0] wr_col_n, cur_col_n, clr_col, clr_col_n;
    logic [7:0] wr_glyph_n;
    // Set once the final sweep cell has been issued; the next edge returns to
    // IDLE so char_ready rises exactly as the last write strobe drops.
    logic       clr_last, clr_last_n;

    // Row/column after one glyph advance, and row after a newline.
    logic [5:0] nl_row, adv_row;
    logic [6:0] adv_col;
    logic [7:0] tab_col;

    assign nl_row  = (cur_row == LAST_ROW) ? 6'd0 : 6'(cur_row + 6'd1);
    assign adv_col = (cur_col == LAST_COL) ? 7'd0 : 7'(cur_col + 7'd1);
    assign adv_row = (cur_col == LAST_COL) ? nl_row : cur_row;
    assign tab_col = 8'(({1'b0, cur_col} & TAB_MASK) + TAB_STEP);

    // Ready depends only on state; held low while reset is asserted.
    assign char_ready = (state == IDLE) && !rst;
    assign busy       = (state == CLEAR);

    // State and registered write port / cursor / sweep counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RST_ST;
            we       <= 1'b0;
            wr_row   <= 6'd0;
            wr_col   <= 7'd0;
            wr_glyph <= 8'd0;
            cur_row  <= 6'd0;
            cur_col  <= 7'd0;
            clr_row  <= 6'd0;
            clr_col  <= 7'd0;
            clr_last <= 1'b0;
        end else begin
            state    <= state_n;
            we       <= we_n;
            wr_row   <= wr_row_n;
            wr_col   <= wr_col_n;
            wr_glyph <= wr_glyph_n;
            cur_row  <= cur_row_n;
            cur_col  <= cur_col_n;
            clr_row  <= clr_row_n;
            clr_col  <= clr_col_n;
            clr_last <= clr_last_n;
        end
    end

    // Next-state: byte interpretation in IDLE, cell-by-cell sweep in CLEAR.
    always_comb begin
        state_n    = state;
        we_n       = 1'b0;
        wr_row_n   = wr_row;
        wr_col_n   = wr_col;
        wr_glyph_n = wr_glyph;
        cur_row_n  = cur_row;
        cur_col_n  = cur_col;
        clr_row_n  = clr_row;
        clr_col_n  = clr_col;
        clr_last_n = clr_last;
        case (state)
            IDLE: begin
                if (char_valid) begin
                    case (char_in)
                        8'h0D: cur_col_n = 7'd0;
                        8'h0A: begin
                            cur_col_n = 7'd0;
                            cur_row_n = nl_row;
                        end
                        8'h08: begin
                            if (cur_col != 7'd0) begin
                                cur_col_n  = 7'(cur_col - 7'd1);
                                we_n       = 1'b1;
                                wr_row_n   = cur_row;
                                wr_col_n   = 7'(cur_col - 7'd1);
                                wr_glyph_n = FILL;
                            end else if (cur_row != 6'd0) begin
                                cur_row_n  = 6'(cur_row - 6'd1);
                                cur_col_n  = LAST_COL;
                                we_n       = 1'b1;
                                wr_row_n   = 6'(cur_row - 6'd1);
                                wr_col_n   = LAST_COL;
                                wr_glyph_n = FILL;
                            end
                        end
                        8'h09: begin
                            if (tab_col >= COLS_8) begin
                                cur_col_n = 7'd0;
                                cur_row_n = nl_row;
                            end else begin
                                cur_col_n = tab_col[6:0];
                            end
                        end
                        8'h0C: begin
                            // The accepting edge itself issues cell (0,0);
                            // the sweep counter resumes from the next cell.
                            cur_row_n  = 6'd0;
                            cur_col_n  = 7'd0;
                            we_n       = 1'b1;
                            wr_row_n   = 6'd0;
                            wr_col_n   = 7'd0;
                            wr_glyph_n = FILL;
                            clr_row_n  = (LAST_COL == 7'd0) ? 6'd1 : 6'd0;
                            clr_col_n  = (LAST_COL == 7'd0) ? 7'd0 : 7'd1;
                            clr_last_n = (LAST_COL == 7'd0) && (LAST_ROW == 6'd0);
                            state_n    = CLEAR;
                        end
                        default: begin
                            if (char_in >= 8'h20 && char_in <= 8'h7E) begin
                                we_n       = 1'b1;
                                wr_row_n   = cur_row;
                                wr_col_n   = cur_col;
                                wr_glyph_n = char_in;
                                cur_row_n  = adv_row;
                                cur_col_n  = adv_col;
                            end
                        end
                    endcase
                end
            end
            CLEAR: begin
                if (clr_last) begin
                    state_n    = IDLE;
                    clr_last_n = 1'b0;
                end else begin
                    we_n       = 1'b1;
                    wr_row_n   = clr_row;
                    wr_col_n   = clr_col;
                    wr_glyph_n = FILL;
                    if (clr_col == LAST_COL) begin
                        clr_col_n = 7'd0;
                        if (clr_row == LAST_ROW) begin
                            clr_row_n  = 6'd0;
                            clr_last_n = 1'b1;
                        end else begin
                            clr_row_n = 6'(clr_row + 6'd1);
                        end
                    end else begin
                        clr_col_n = 7'(clr_col + 7'd1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_text_console.sv
// Directed self-checking bench for text_console (default 60x80 geometry).
module tb_text_console;

    localparam int ROWS = 60;
    localparam int COLS = 80;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] char_in;
    logic       char_valid;
    logic       char_ready, busy, we;
    logic [5:0] wr_row, cur_row;
    logic [6:0] wr_col, cur_col;
    logic [7:0] wr_glyph;

    int checks = 0;
    int errors = 0;

    text_console dut (
        .clk(clk), .rst(rst), .char_in(char_in), .char_valid(char_valid),
        .char_ready(char_ready), .busy(busy), .we(we), .wr_row(wr_row),
        .wr_col(wr_col), .wr_glyph(wr_glyph), .cur_row(cur_row), .cur_col(cur_col)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] ch;
        logic       ew;
        logic [5:0] er;
        logic [6:0] ec;
        logic [7:0] eg;
        logic [5:0] ecr;
        logic [6:0] ecc;
    } vec_t;

    vec_t vt[19];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive one byte, starting #1 after a rising edge (or at a falling edge);
    // consecutive calls present bytes on consecutive edges.
    task automatic apply(input logic [7:0] b, input bit do_chk, input logic ew,
                         input logic [5:0] er, input logic [6:0] ec, input logic [7:0] eg,
                         input logic [5:0] ecr, input logic [6:0] ecc, input string nm);
        int n = 0;
        while (!char_ready && n < 10000) begin
            @(posedge clk); #1;
            n++;
        end
        if (!char_ready) begin
            checks++; errors++;
            $display("FAIL %s: char_ready timeout got 0 expected 1", nm);
        end
        char_in = b;
        char_valid = 1'b1;
        @(posedge clk); #1;
        char_valid = 1'b0;
        if (do_chk) begin
            chk({nm, ".we"}, 32'(we), 32'(ew));
            if (ew) begin
                chk({nm, ".wr_row"}, 32'(wr_row), 32'(er));
                chk({nm, ".wr_col"}, 32'(wr_col), 32'(ec));
                chk({nm, ".wr_glyph"}, 32'(wr_glyph), 32'(eg));
            end
            chk({nm, ".cur_row"}, 32'(cur_row), 32'(ecr));
            chk({nm, ".cur_col"}, 32'(cur_col), 32'(ecc));
        end
    endtask

    task automatic send(input logic [7:0] b);
        apply(b, 1'b0, 1'b0, 6'd0, 7'd0, 8'd0, 6'd0, 7'd0, "send");
    endtask

    // Called just after the edge that issues (or will issue) the first sweep
    // write; samples every falling edge for ROWS*COLS cycles.
    task automatic sweep_check(input string nm);
        int good = 0;
        logic [5:0] fr = '1, lr = '0;
        logic [6:0] fc = '1, lc = '0;
        for (int i = 0; i < ROWS * COLS; i++) begin
            @(negedge clk);
            if (i == 0) begin fr = wr_row; fc = wr_col; end
            if (i == ROWS * COLS - 1) begin lr = wr_row; lc = wr_col; end
            if (we === 1'b1 && wr_glyph === 8'h20 && char_ready === 1'b0 && busy === 1'b1 &&
                wr_row === 6'(i / COLS) && wr_col === 7'(i % COLS))
                good++;
        end
        chk({nm, ".good_cells"}, 32'(good), 32'(ROWS * COLS));
        chk({nm, ".first_row"}, 32'(fr), 32'd0);
        chk({nm, ".first_col"}, 32'(fc), 32'd0);
        chk({nm, ".last_row"}, 32'(lr), 32'(ROWS - 1));
        chk({nm, ".last_col"}, 32'(lc), 32'(COLS - 1));
        @(negedge clk);
        chk({nm, ".ready_after"}, 32'(char_ready), 32'd1);
        chk({nm, ".we_after"}, 32'(we), 32'd0);
        chk({nm, ".busy_after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        // ch, we, wr_row, wr_col, glyph, cur_row, cur_col
        vt[0]  = '{8'h41, 1, 6'd0, 7'd0,  8'h41, 6'd0, 7'd1};
        vt[1]  = '{8'h42, 1, 6'd0, 7'd1,  8'h42, 6'd0, 7'd2};
        vt[2]  = '{8'h07, 0, 6'd0, 7'd0,  8'h00, 6'd0, 7'd2};
        vt[3]  = '{8'h63, 1, 6'd0, 7'd2,  8'h63, 6'd0, 7'd3};
        vt[4]  = '{8'h64, 1, 6'd0, 7'd3,  8'h64, 6'd0, 7'd4};
        vt[5]  = '{8'h65, 1, 6'd0, 7'd4,  8'h65, 6'd0, 7'd5};
        vt[6]  = '{8'h09, 0, 6'd0, 7'd0,  8'h00, 6'd0, 7'd8};
        vt[7]  = '{8'h09, 0, 6'd0, 7'd0,  8'h00, 6'd0, 7'd16};
        vt[8]  = '{8'h08, 1, 6'd0, 7'd15, 8'h20, 6'd0, 7'd15};
        vt[9]  = '{8'h0D, 0, 6'd0, 7'd0,  8'h00, 6'd0, 7'd0};
        vt[10] = '{8'h08, 0, 6'd0, 7'd0,  8'h00, 6'd0, 7'd0};
        vt[11] = '{8'h0A, 0, 6'd0, 7'd0,  8'h00, 6'd1, 7'd0};
        vt[12] = '{8'h0A, 0, 6'd0, 7'd0,  8'h00, 6'd2, 7'd0};
        vt[13] = '{8'h0A, 0, 6'd0, 7'd0,  8'h00, 6'd3, 7'd0};
        vt[14] = '{8'h08, 1, 6'd2, 7'd79, 8'h20, 6'd2, 7'd79};
        vt[15] = '{8'h63, 1, 6'd2, 7'd79, 8'h63, 6'd3, 7'd0};
        vt[16] = '{8'h80, 0, 6'd0, 7'd0,  8'h00, 6'd3, 7'd0};
        vt[17] = '{8'h7E, 1, 6'd3, 7'd0,  8'h7E, 6'd3, 7'd1};
        vt[18] = '{8'h7F, 0, 6'd0, 7'd0,  8'h00, 6'd3, 7'd1};

        rst = 1'b1;
        char_in = 8'h00;
        char_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset.we", 32'(we), 32'd0);
        chk("reset.wr_glyph", 32'(wr_glyph), 32'd0);
        chk("reset.cur", 32'({cur_row, cur_col}), 32'd0);
        chk("reset.ready", 32'(char_ready), 32'd0);
        chk("reset.busy", 32'(busy), 32'd1);
        rst = 1'b0;
        sweep_check("reset_sweep");

        // Table: back-to-back bytes from (0,0).
        @(posedge clk); #1;
        for (int i = 0; i < 19; i++)
            apply(vt[i].ch, 1'b1, vt[i].ew, vt[i].er, vt[i].ec, vt[i].eg,
                  vt[i].ecr, vt[i].ecc, $sformatf("vec%0d", i));

        // FF mid-screen with "X" held through the sweep.
        @(negedge clk);
        char_in = 8'h0C;
        char_valid = 1'b1;
        @(posedge clk); #1;
        char_in = 8'h58;
        chk("ff.cur", 32'({cur_row, cur_col}), 32'd0);
        sweep_check("ff_sweep");
        @(posedge clk); #1;
        char_valid = 1'b0;
        chk("ff_x.we", 32'(we), 32'd1);
        chk("ff_x.addr", 32'({wr_row, wr_col}), 32'd0);
        chk("ff_x.glyph", 32'(wr_glyph), 32'h58);
        chk("ff_x.cur_col", 32'(cur_col), 32'd1);

        // Reset at sweep cycle 100 aborts and restarts a full sweep.
        send(8'h0C);
        repeat (99) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst.we", 32'(we), 32'd0);
        chk("midrst.cur", 32'({cur_row, cur_col}), 32'd0);
        chk("midrst.ready", 32'(char_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        sweep_check("rst_sweep");

        // TAB at col 77 wraps to the next row.
        @(posedge clk); #1;
        for (int i = 0; i < 77; i++) send(8'h2E);
        apply(8'h09, 1'b1, 1'b0, 6'd0, 7'd0, 8'd0, 6'd1, 7'd0, "tab77");

        // (4,10): CR then LF, neither writes.
        for (int i = 0; i < 3; i++) send(8'h0A);
        for (int i = 0; i < 10; i++) send(8'h2E);
        apply(8'h0D, 1'b1, 1'b0, 6'd0, 7'd0, 8'd0, 6'd4, 7'd0, "cr");
        apply(8'h0A, 1'b1, 1'b0, 6'd0, 7'd0, 8'd0, 6'd5, 7'd0, "lf");

        // Last cell: write at (59,79) then wrap to (0,0).
        for (int i = 0; i < 54; i++) send(8'h0A);
        for (int i = 0; i < 79; i++) send(8'h2E);
        chk("pre_z.cur", 32'({cur_row, cur_col}), 32'({6'd59, 7'd79}));
        apply(8'h5A, 1'b1, 1'b1, 6'd59, 7'd79, 8'h5A, 6'd0, 7'd0, "z_wrap");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/text_console.md
# text_console

Character-stream terminal front end that turns a stream of ASCII bytes from the CPU/Forth side into cell writes on the text screen memory's write port (`we`/`wr_row`/`wr_col`/`wr_glyph`). It keeps a hardware cursor over the 60x80 grid and interprets a small set of control codes: CR, LF, BS, TAB and FF. FF triggers a full-screen clear sweep. Software pushes bytes through a valid/ready handshake and never computes cell addresses itself.

## Interface
Parameters:
- `ROWS`, 60, screen rows; must be ≤ 64.
- `COLS`, 80, screen columns; must be ≤ 128.
- `FILL`, 8'h20, glyph written by clear and backspace.
- `TAB_W`, 8, tab stop spacing; must be a power of two.
- `CLEAR_ON_RESET`, 1, when 1 a clear sweep runs after reset release.

Ports:
- `clk`  in  1  the single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `char_in`  in  8  ASCII byte from CPU.
- `char_valid`  in  1  `char_in` is valid.
- `char_ready`  out  1  console can accept a byte this cycle.
- `busy`  out  1  clear sweep in progress.
- `we`  out  1  write strobe to screen memory, one cell per cycle.
- `wr_row`  out  6  target row, 0..ROWS-1.
- `wr_col`  out  7  target column, 0..COLS-1.
- `wr_glyph`  out  8  byte to store.
- `cur_row`  out  6  cursor row.
- `cur_col`  out  7  cursor column.

## Operation
- States:
  - IDLE: `char_ready`=1.
  - CLEAR: `char_ready`=0, `busy`=1.
- Handshake:
  - A byte is accepted on a rising edge with `char_valid` && `char_ready`.
  - At most one byte is accepted per cycle.
  - The byte must be held until accepted.
- Accepted byte handling:
  - 0x20..0x7E: write the glyph at (cur_row, cur_col), then advance the cursor.
  - 0x0D CR: `cur_col`=0; no write.
  - 0x0A LF: `cur_col`=0 and advance the row; no write.
  - 0x08 BS at col>0: move to col-1 and write FILL there.
  - 0x08 BS at col=0 and row>0: move to (row-1, COLS-1) and write FILL there.
  - 0x08 BS at (0,0): no-op, no write.
  - 0x09 TAB: `cur_col` = next multiple of TAB_W strictly greater than `cur_col`. If the result is ≥ COLS, do a newline instead. No write.
  - 0x0C FF: cursor goes to (0,0) and the block enters CLEAR.
  - All other bytes (other controls, ≥0x7F): accepted and discarded, with no write and no cursor change.
- Cursor advance:
  - col+1.
  - At col=COLS-1: col=0 and advance the row.
  - Row advance is row+1; at row ROWS-1 it wraps to 0.
  - There is no scrolling; overwrites at the top are intended.
- CLEAR: writes FILL to every cell in row-major order, (0,0) through (ROWS-1,COLS-1), one cell per cycle. The block returns to IDLE after the last cell.

## Timing
- Reset values: `we`=0, `wr_row`=0, `wr_col`=0, `wr_glyph`=0, `cur_row`=0, `cur_col`=0.
- During reset:
  - `char_ready`=0.
  - `busy`=CLEAR_ON_RESET.
  - State = CLEAR if CLEAR_ON_RESET, else IDLE.
- Write outputs are registered. For a byte accepted at edge k:
  - `we`, `wr_row`, `wr_col` and `wr_glyph` are valid from k until k+1, with `we` high for exactly that cycle.
  - The cursor outputs show the updated position from edge k.
- CLEAR timing:
  - The first sweep write appears on the edge that accepts FF, or on the first edge after `rst` falls.
  - Exactly ROWS*COLS consecutive `we` cycles follow.
  - `char_ready` is low and `busy` is high throughout those cycles.
  - `char_ready` rises in the cycle after the last sweep write; there are no gaps and no dead cycles.
- `char_ready` is a function of state only. It never depends combinationally on `char_valid`.
- `rst` asserted mid-sweep or mid-write aborts immediately: `we` drops asynchronously and the cursor returns to (0,0).
- `char_valid` held high during CLEAR: the byte is not accepted and is taken on the first IDLE edge.

## Test plan
- Reset with CLEAR_ON_RESET=1 → 4800 consecutive `we` cycles with `wr_glyph`=0x20.
  - The first address is (0,0) and the last is (59,79).
  - `char_ready` goes high on cycle 4801.
- Bytes "AB" back-to-back from (0,0):
  - `we` pulses with (0,0,0x41) then (0,1,0x42).
  - Cursor ends at (0,2).
- Cursor at (59,79), byte 0x5A → write at (59,79), cursor moves to (0,0).
- Backspace cases:
  - At (3,0): BS writes 0x20 at (2,79) and the cursor moves to (2,79).
  - At (0,0): BS produces no `we` pulse.
- Tab and CR/LF:
  - At col 5: TAB gives col 8.
  - At col 77: TAB gives (row+1, 0).
  - At (4,10): CR then LF gives (5,0) with no `we` pulses.
- FF accepted mid-screen with `char_valid` held for "X":
  - The sweep runs for 4800 cycles.
  - "X" is then written at (0,0).
  - Asserting `rst` at sweep cycle 100 instead restarts a full 4800-cycle sweep.
